// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared types, default timing constants and width helpers
//                for the push-button conditioning bank.
//  Revision    : 1.0  initial release
// ============================================================================
package button_pkg;

    // Auto-repeat state per channel
    typedef enum logic [1:0] {
        RPT_IDLE       = 2'd0,
        RPT_WAIT_FIRST = 2'd1,
        RPT_REPEATING  = 2'd2
    } rpt_state_t;

    // Default timings for a 100 MHz system clock
    localparam int DEB_10MS        = 1_000_000;
    localparam int REP_DELAY_500MS = 50_000_000;
    localparam int REP_RATE_100MS  = 10_000_000;

    // Bits needed for a counter that must be able to hold the value v
    function automatic int cnt_width(input int v);
        return $clog2(v + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One push-button channel: 2-flop synchroniser, debounce
//                counter, edge detection and hold-to-repeat state machine.
//                All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_10MS,
    parameter int REPEAT_DELAY = REP_DELAY_500MS,
    parameter int REPEAT_RATE  = REP_RATE_100MS
) (
    input  logic clk,
    input  logic rst,         // synchronous, active-low
    input  logic btn,         // raw asynchronous pin
    input  logic repeat_en,   // synchronous to clk
    output logic level,
    output logic press,
    output logic released,
    output logic pulse
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int HW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [DW-1:0] C_DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] C_DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] C_RATE_LAST  = HW'(REPEAT_RATE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_dcnt;
    logic          r_level;
    logic          r_en_d;
    logic          r_press;
    logic          r_release;
    logic          r_pulse;
    rpt_state_t    r_state;
    logic [HW-1:0] r_hcnt;

    logic          w_differs;
    logic          w_flip;
    logic          w_rise;
    logic          w_fall;
    logic          w_en_rise;
    logic          w_fire;
    rpt_state_t    w_state_next;
    logic [HW-1:0] w_hcnt_next;

    // Debounce events: level flips once the input has disagreed long enough
    always_comb begin
        w_differs = r_sync2 ^ r_level;
        w_flip    = w_differs && (r_dcnt == C_DEB_LAST);
        w_rise    = w_flip && !r_level;
        w_fall    = w_flip &&  r_level;
        w_en_rise = repeat_en && !r_en_d;
    end

    // Synchroniser, debounce counter and edge pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_en_d    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_en_d    <= repeat_en;
            if (!w_differs || w_flip) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
            r_press   <= w_rise;
            r_release <= w_fall;
            // Repeat pulses never coincide with press: the first one is at
            // least one cycle after entering WAIT_FIRST.
            r_pulse   <= w_rise | w_fire;
        end
    end

    // Repeat FSM state and hold counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RPT_IDLE;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
        end
    end

    // Repeat FSM next-state, hold counter and repeat fire decision
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        w_fire       = 1'b0;
        case (r_state)
            RPT_IDLE: begin
                w_hcnt_next = '0;
                // Enter on a fresh press, or when repeat is enabled while the
                // button is already held (and not falling right now).
                if (repeat_en && (w_rise || (w_en_rise && r_level && !w_fall))) begin
                    w_state_next = RPT_WAIT_FIRST;
                end
            end
            RPT_WAIT_FIRST: begin
                if (w_fall || !repeat_en) begin
                    w_state_next = RPT_IDLE;
                    w_hcnt_next  = '0;
                end else if (r_hcnt == C_DELAY_LAST) begin
                    w_fire       = 1'b1;
                    w_state_next = RPT_REPEATING;
                    w_hcnt_next  = '0;
                end else begin
                    w_hcnt_next  = r_hcnt + HW'(1);
                end
            end
            RPT_REPEATING: begin
                if (w_fall || !repeat_en) begin
                    w_state_next = RPT_IDLE;
                    w_hcnt_next  = '0;
                end else if (r_hcnt == C_RATE_LAST) begin
                    w_fire       = 1'b1;
                    w_hcnt_next  = '0;
                end else begin
                    w_hcnt_next  = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_next = RPT_IDLE;
                w_hcnt_next  = '0;
            end
        endcase
    end

    assign level    = r_level;
    assign press    = r_press;
    assign released = r_release;
    assign pulse    = r_pulse;

endmodule : button_channel
`default_nettype wire

// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : button_bank
//  Description : Bank of N independent push-button conditioners. The
//                debounced-falling-edge output is named "released" because
//                "release" is a reserved word in SystemVerilog.
//  Revision    : 1.0  initial release
// ============================================================================
module button_bank
    import button_pkg::*;
#(
    parameter int N            = 5,
    parameter int DEB_CYCLES   = DEB_10MS,
    parameter int REPEAT_DELAY = REP_DELAY_500MS,
    parameter int REPEAT_RATE  = REP_RATE_100MS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] released,
    output logic [N-1:0] pulse
);

    // One fully independent conditioner per button
    for (genvar i = 0; i < N; i++) begin : g_chan
        button_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn[i]),
            .repeat_en (repeat_en[i]),
            .level     (level[i]),
            .press     (press[i]),
            .released  (released[i]),
            .pulse     (pulse[i])
        );
    end

endmodule : button_bank
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_bank
//  Description : Randomised self-checking bench for button_bank against a
//                window/schedule based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_bank;

    localparam int N     = 3;
    localparam int DEB   = 4;
    localparam int DLY   = 10;
    localparam int RATE  = 3;
    localparam int NCYC  = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] repeat_en;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] released;
    logic [N-1:0] pulse;

    int n_total = 0;
    int n_bad   = 0;
    int cur_cyc = 0;

    button_bank #(
        .N            (N),
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .repeat_en (repeat_en),
        .level     (level),
        .press     (press),
        .released  (released),
        .pulse     (pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[t] holds the pin value sampled at edge t; level flips at edge t
    // when every synchronised sample seen over the last DEB edges disagreed
    // with level and no flip/reset happened inside that window.
    logic [N-1:0] hist [0:NCYC+8];
    logic [N-1:0] m_level, m_press, m_rel, m_pulse, m_prev_en;
    int           m_last_flip [N];
    int           m_next_fire [N];
    bit           m_active    [N];

    task automatic model_step(input int t, input logic r, input logic [N-1:0] b,
                              input logic [N-1:0] en);
        hist[t] = b;
        if (!r) begin
            hist[t]   = '0;
            hist[t-1] = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_pulse = '0; m_prev_en = '0;
            for (int c = 0; c < N; c++) begin
                m_last_flip[c] = t;
                m_active[c]    = 1'b0;
                m_next_fire[c] = 0;
            end
            return;
        end
        for (int c = 0; c < N; c++) begin
            bit flip, rise, fall, fire;
            flip = 1'b0;
            fire = 1'b0;
            if (t - DEB >= m_last_flip[c]) begin
                flip = 1'b1;
                for (int e = t - DEB + 1; e <= t; e++)
                    if (hist[e-2][c] == m_level[c]) flip = 1'b0;
            end
            rise = flip && !m_level[c];
            fall = flip &&  m_level[c];
            if (flip) m_last_flip[c] = t;
            if (m_active[c]) begin
                if (fall || !en[c]) begin
                    m_active[c] = 1'b0;
                end else if (t == m_next_fire[c]) begin
                    fire = 1'b1;
                    m_next_fire[c] = t + RATE;
                end
            end else if (en[c] && (rise || (m_level[c] && !fall && !m_prev_en[c]))) begin
                m_active[c]    = 1'b1;
                m_next_fire[c] = t + DLY;
            end
            m_level[c] = m_level[c] ^ flip;
            m_press[c] = rise;
            m_rel[c]   = fall;
            m_pulse[c] = rise | fire;
        end
        m_prev_en = en;
    endtask

    task automatic check_val(input string tag, input logic [N-1:0] got,
                             input logic [N-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cur_cyc, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    int seg_left [N];
    logic [N-1:0] tgt;

    initial begin
        rst = 1'b0; btn = '0; repeat_en = '0; tgt = '0;
        for (int c = 0; c < N; c++) seg_left[c] = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            cur_cyc = cyc;
            if (cyc > 0) begin
                check_val("level",    level,    m_level);
                check_val("press",    press,    m_press);
                check_val("released", released, m_rel);
                check_val("pulse",    pulse,    m_pulse);
            end
            if (cyc < 80) begin
                // clean press ch0, bounce ch1, repeat ch2 with enable drop
                // and a reset while ch2 is in its first-repeat wait
                rst          = (cyc >= 2) && (cyc != 42);
                btn[0]       = (cyc >= 4);
                btn[1]       = (cyc >= 4 && cyc < 24) ? ((cyc - 4) % 4 != 3) : 1'b0;
                btn[2]       = (cyc >= 4 && cyc < 60);
                repeat_en    = 3'b100;
                if (cyc == 35 || cyc == 36) repeat_en[2] = 1'b0;
                if (cyc >= 65) repeat_en = 3'b101;
                tgt = btn;
            end else begin
                rst = ($urandom_range(0, 399) != 0);
                for (int c = 0; c < N; c++) begin
                    if (seg_left[c] == 0) begin
                        tgt[c] = ~tgt[c];
                        seg_left[c] = ($urandom_range(0, 3) == 0) ?
                                      int'($urandom_range(1, 5)) :
                                      int'($urandom_range(6, 40));
                    end
                    btn[c] = tgt[c];
                    seg_left[c]--;
                    if ($urandom_range(0, 24) == 0) repeat_en[c] = ~repeat_en[c];
                end
            end
            @(posedge clk);
            model_step(cyc + 2, rst, btn, repeat_en);
        end
        @(negedge clk);
        cur_cyc = NCYC;
        check_val("level",    level,    m_level);
        check_val("press",    press,    m_press);
        check_val("released", released, m_rel);
        check_val("pulse",    pulse,    m_pulse);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_button_bank
`default_nettype wire
